// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
//   Bundles the SPI pins and the fabric-side TX/RX handshake of spi_slave.
//   clk and rst are not part of the bundle; they remain plain module ports.
//
//   SPI side    : sclk, cs_n, mosi (from master), miso, miso_oe (to master)
//   TX side     : tx_data, tx_valid (from fabric), tx_ready (to fabric)
//   RX side     : rx_data, rx_valid (to fabric)
//   Status      : tx_underrun, busy (to fabric)
//
//   modport slave  : the view taken by spi_slave itself
//   modport master : the opposite view (SPI master plus fabric producer)
// -----------------------------------------------------------------------------
interface spi_slave_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI target that oversamples SCLK/CS_N/MOSI in the system clock domain and
//   shifts DATA_W-bit words MSB-first in both directions. A one-word TX holding
//   buffer (ready/valid) feeds the shift register at each word boundary; each
//   completed RX word is presented with a one-cycle rx_valid strobe. Words may
//   follow back-to-back while cs_n stays low.
//
//   Parameters : DATA_W (2..32) word length, CPOL idle SCLK level,
//                CPHA 0 = sample leading / shift trailing,
//                     1 = shift leading  / sample trailing.
//   Ports      : clk  system clock, at least 4x SCLK
//                rst  synchronous reset, active-high
//                bus  spi_slave_if.slave (SPI pins, TX/RX handshake, status)
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int DATA_W = 8,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Synchronisers plus one history stage for edge detection.
    logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_h_q, sclk_h_d;
    logic cs_s1_q,   cs_s1_d,   cs_s2_q,   cs_s2_d,   cs_h_q,   cs_h_d;
    logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;

    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] hold_q,     hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] rx_data_q,  rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic              miso_q,     miso_d;
    logic              busy_q,     busy_d;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge;
    logic cs_fall, cs_rise, word_done;

    // -------------------------------------------------------------------------
    // Edge decode on the synchronised inputs
    // -------------------------------------------------------------------------
    assign sclk_rise   =  sclk_s2_q & ~sclk_h_q;
    assign sclk_fall   = ~sclk_s2_q &  sclk_h_q;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    assign cs_fall     =  cs_h_q & ~cs_s2_q;
    assign cs_rise     = ~cs_h_q &  cs_s2_q;

    assign word_done   = (state_q == ACTIVE) && sample_edge && (bit_cnt_q == LAST_BIT);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with <= so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default on entry,
    // so no path through the block can leave it holding a value (no latch).
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall)   state_d = LOAD;
                LOAD:                   state_d = ACTIVE;
                ACTIVE:  if (word_done) state_d = LOAD;
                default:                state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM outputs and datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        sclk_s1_d   = bus.sclk;
        sclk_s2_d   = sclk_s1_q;
        sclk_h_d    = sclk_s2_q;
        cs_s1_d     = bus.cs_n;
        cs_s2_d     = cs_s1_q;
        cs_h_d      = cs_s2_q;
        mosi_s1_d   = bus.mosi;
        mosi_s2_d   = mosi_s1_q;

        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;

        if (cs_rise || (state_q == IDLE)) begin
            // Deselected or aborting: any partial word is dropped. A word
            // already moved into the shift register is lost; the holding
            // buffer is left untouched.
            tx_shift_d = '0;
            rx_shift_d = '0;
            bit_cnt_d  = '0;
        end else if (state_q == LOAD) begin
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d  = '0;
                underrun_d  = 1'b1;
            end
        end else begin
            if (sample_edge) begin
                rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s2_q};
                bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    rx_data_d  = rx_shift_d;
                    rx_valid_d = 1'b1;
                end
            end
            // With no sample taken yet in this word the loaded MSB stays on
            // miso: this skips the first CPHA=1 leading edge and, for CPHA=0,
            // the trailing edge of the previous word's last bit in a burst.
            if (shift_edge && (bit_cnt_q != '0)) begin
                tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end
        end

        // Fabric capture uses the pre-LOAD fullness, so a word written in the
        // LOAD cycle lands in the buffer and waits for the next word.
        if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
        miso_d = busy_d ? tx_shift_d[DATA_W-1] : 1'b0;
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // The cs_n chain resets to "low" so that a cs_n held low across reset never
    // produces a falling edge; the aborted frame stays ignored until cs_n is
    // seen high and then low again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q   <= CPOL;
            sclk_s2_q   <= CPOL;
            sclk_h_q    <= CPOL;
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_h_q      <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            sclk_h_q    <= sclk_h_d;
            cs_s1_q     <= cs_s1_d;
            cs_s2_q     <= cs_s2_d;
            cs_h_q      <= cs_h_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
        end
    end

    // NOTE: the holding-buffer data word has no reset; hold_full_q qualifies
    // it, so its content is never observed before a capture writes it.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.miso        = miso_q;
    assign bus.miso_oe     = busy_q;
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//   Drives two spi_slave instances from one bench-side SPI master: dut0 in
//   mode 0 and dut3 in mode 3 (CPOL=1, CPHA=1). SCLK and MOSI are shared; each
//   DUT has its own cs_n, so the deselected DUT sees SCLK activity it must
//   ignore. Words the master sends are pushed to a per-DUT queue and popped
//   when that DUT strobes rx_valid.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int HALF = 4;  // SCLK half period in clk cycles (SCLK = clk/8)

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       sclk_m = 1'b0;
    logic       mosi_m = 1'b0;
    logic       cs0_n  = 1'b1;
    logic       cs3_n  = 1'b1;
    logic [7:0] txd0   = '0;
    logic       txv0   = 1'b0;
    logic [7:0] txd3   = '0;
    logic       txv3   = 1'b0;

    int checks = 0;
    int errors = 0;
    int urun0  = 0;
    int urun3  = 0;

    logic [7:0] rx_exp0[$];
    logic [7:0] rx_exp3[$];

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(8)) bus0 ();
    spi_slave_if #(.DATA_W(8)) bus3 ();

    assign bus0.sclk     = sclk_m;
    assign bus0.mosi     = mosi_m;
    assign bus0.cs_n     = cs0_n;
    assign bus0.tx_data  = txd0;
    assign bus0.tx_valid = txv0;
    assign bus3.sclk     = sclk_m;
    assign bus3.mosi     = mosi_m;
    assign bus3.cs_n     = cs3_n;
    assign bus3.tx_data  = txd3;
    assign bus3.tx_valid = txv3;

    spi_slave #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    spi_slave #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every rx_valid must match the oldest queued word.
    always @(negedge clk) begin
        if (bus0.rx_valid === 1'b1) begin
            if (rx_exp0.size() == 0) check("dut0 unexpected rx_valid", bus0.rx_valid, 1'b0);
            else                     check("dut0 rx_data", bus0.rx_data, rx_exp0.pop_front());
        end
        if (bus3.rx_valid === 1'b1) begin
            if (rx_exp3.size() == 0) check("dut3 unexpected rx_valid", bus3.rx_valid, 1'b0);
            else                     check("dut3 rx_data", bus3.rx_data, rx_exp3.pop_front());
        end
        if (bus0.tx_underrun === 1'b1) urun0++;
        if (bus3.tx_underrun === 1'b1) urun3++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input bit m3, input logic [7:0] d);
        if (m3) begin txd3 = d; txv3 = 1'b1; end
        else    begin txd0 = d; txv0 = 1'b1; end
        @(negedge clk);
        txv0 = 1'b0;
        txv3 = 1'b0;
    endtask

    // One word (or its first nbits bits) from the master, MSB first.
    // m3=0: mode 0 on dut0, m3=1: mode 3 on dut3.
    task automatic xfer(input bit m3, input logic [7:0] mo, input int nbits,
                        output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!m3) mosi_m = mo[i];
            wait_clk(HALF);
            sclk_m = ~m3;                      // leading edge
            if (!m3) mi = {mi[6:0], bus0.miso};
            else     mosi_m = mo[i];
            wait_clk(HALF);
            sclk_m = m3;                       // trailing edge
            if (m3)  mi = {mi[6:0], bus3.miso};
        end
    endtask

    initial begin
        logic [7:0] mi;
        int         u_base;

        // ---------------- reset state ----------------
        wait_clk(3);
        check("reset miso",        bus0.miso,        1'b0);
        check("reset miso_oe",     bus0.miso_oe,     1'b0);
        check("reset tx_ready",    bus0.tx_ready,    1'b1);
        check("reset rx_data",     bus0.rx_data,     8'h00);
        check("reset rx_valid",    bus0.rx_valid,    1'b0);
        check("reset tx_underrun", bus0.tx_underrun, 1'b0);
        check("reset busy",        bus0.busy,        1'b0);
        rst = 1'b0;
        wait_clk(4);

        // ---------------- mode 0 single word ----------------
        preload(1'b0, 8'hA5);
        check("t1 tx_ready after capture", bus0.tx_ready, 1'b0);
        u_base = urun0;
        cs0_n  = 1'b0;
        wait_clk(4);
        check("t1 first bit by 4 clk", bus0.miso,    1'b1);
        check("t1 miso_oe selected",   bus0.miso_oe, 1'b1);
        check("t1 busy selected",      bus0.busy,    1'b1);
        wait_clk(2);
        check("t1 tx_ready after LOAD", bus0.tx_ready, 1'b1);
        check("t1 no underrun at start", 32'(urun0 - u_base), 32'd0);
        rx_exp0.push_back(8'h3C);
        xfer(1'b0, 8'h3C, 8, mi);
        check("t1 master got", mi, 8'hA5);
        wait_clk(HALF);
        cs0_n = 1'b1;
        wait_clk(8);
        check("t1 miso_oe after deselect", bus0.miso_oe, 1'b0);

        // ---------------- continuous 2-word burst ----------------
        preload(1'b0, 8'h12);
        cs0_n = 1'b0;
        wait_clk(6);
        preload(1'b0, 8'h34);  // word 1 already in the shift register
        rx_exp0.push_back(8'hF0);
        rx_exp0.push_back(8'h0F);
        xfer(1'b0, 8'hF0, 8, mi);
        check("burst word1 master got", mi, 8'h12);
        xfer(1'b0, 8'h0F, 8, mi);
        check("burst word2 master got", mi, 8'h34);
        wait_clk(HALF);
        cs0_n = 1'b1;
        wait_clk(8);

        // ---------------- underrun ----------------
        u_base = urun0;
        cs0_n  = 1'b0;
        wait_clk(6);
        check("underrun one pulse at start", 32'(urun0 - u_base), 32'd1);
        rx_exp0.push_back(8'h81);
        xfer(1'b0, 8'h81, 8, mi);
        check("underrun miso zeros", mi, 8'h00);
        wait_clk(HALF);
        cs0_n = 1'b1;
        wait_clk(8);

        // ---------------- abort after 5 SCLK, then 0x55 ----------------
        cs0_n = 1'b0;
        wait_clk(6);
        xfer(1'b0, 8'hFF, 5, mi);
        wait_clk(HALF);
        cs0_n = 1'b1;
        wait_clk(8);
        check("abort rx_data kept", bus0.rx_data, 8'h81);
        check("abort busy cleared", bus0.busy,    1'b0);
        cs0_n = 1'b0;
        wait_clk(6);
        rx_exp0.push_back(8'h55);
        xfer(1'b0, 8'h55, 8, mi);
        wait_clk(HALF);
        cs0_n = 1'b1;
        wait_clk(8);
        check("abort next frame rx_data", bus0.rx_data, 8'h55);

        // ---------------- mode 3 on dut3 ----------------
        sclk_m = 1'b1;
        wait_clk(6);
        check("m3 miso_oe deselected", bus3.miso_oe, 1'b0);
        check("m3 miso deselected",    bus3.miso,    1'b0);
        preload(1'b1, 8'h69);
        cs3_n = 1'b0;
        wait_clk(6);
        check("m3 busy selected", bus3.busy, 1'b1);
        rx_exp3.push_back(8'hC3);
        xfer(1'b1, 8'hC3, 8, mi);
        check("m3 master got", mi, 8'h69);
        wait_clk(HALF);
        cs3_n = 1'b1;
        wait_clk(8);
        check("m3 miso_oe after deselect", bus3.miso_oe, 1'b0);
        check("m3 miso after deselect",    bus3.miso,    1'b0);
        sclk_m = 1'b0;
        wait_clk(6);

        // ---------------- reset mid-word with cs_n low ----------------
        preload(1'b0, 8'hE7);
        cs0_n = 1'b0;
        wait_clk(6);
        xfer(1'b0, 8'hAA, 3, mi);
        rst = 1'b1;
        wait_clk(1);
        check("midrst miso",        bus0.miso,        1'b0);
        check("midrst miso_oe",     bus0.miso_oe,     1'b0);
        check("midrst tx_ready",    bus0.tx_ready,    1'b1);
        check("midrst rx_data",     bus0.rx_data,     8'h00);
        check("midrst rx_valid",    bus0.rx_valid,    1'b0);
        check("midrst tx_underrun", bus0.tx_underrun, 1'b0);
        check("midrst busy",        bus0.busy,        1'b0);
        wait_clk(1);
        rst = 1'b0;
        xfer(1'b0, 8'hAA, 5, mi);       // rest of the aborted frame
        check("midrst frame ignored busy", bus0.busy, 1'b0);
        check("midrst frame ignored miso", bus0.miso, 1'b0);
        wait_clk(HALF);
        cs0_n = 1'b1;
        wait_clk(8);
        cs0_n = 1'b0;
        wait_clk(6);
        rx_exp0.push_back(8'h7E);
        xfer(1'b0, 8'h7E, 8, mi);
        check("midrst fresh frame master got", mi, 8'h00);
        wait_clk(HALF);
        cs0_n = 1'b1;
        wait_clk(10);

        // ---------------- all expected words delivered ----------------
        check("dut0 words outstanding", 32'(rx_exp0.size()), 32'd0);
        check("dut3 words outstanding", 32'(rx_exp3.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
